// File: rtl/pac_seq.sv
// pac_seq: table loader and phase-accumulator read sequencer for the pipelined CORDIC sine-amplitude core.
module pac_seq #(
  parameter int ACC_W    = 24,
  parameter int PIPE_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_req,
  input  logic             ld_valid,
  input  logic [47:0]      ld_data,
  output logic             ld_ready,
  input  logic             start,
  input  logic             stop,
  input  logic [ACC_W-1:0] phase0,
  input  logic [ACC_W-1:0] fcw,
  input  logic             fcw_load,
  output logic             cen,
  output logic             wen_trans,
  output logic [5:0]       index_wri,
  output logic [47:0]      D,
  output logic [2:0]       index_qua,
  output logic [5:0]       index_rea,
  output logic [6:0]       index_cor,
  output logic             table_ok,
  output logic             busy,
  output logic             sample_valid,
  output logic             done
);
  localparam int CW = $clog2(PIPE_LAT);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, freq_q, freq_d;
  logic [5:0] addr_q, addr_d, wri_q, wri_d;
  logic [47:0] d_q, d_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [PIPE_LAT-1:0] vsr_q;
  logic cen_q, cen_d, wen_q, wen_d, ok_q, ok_d, rdy_q, done_q, done_d, busy_q;
  logic hs;
  assign hs = ld_valid & rdy_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    freq_d  = freq_q;
    addr_d  = addr_q;
    wri_d   = wri_q;
    d_d     = d_q;
    dcnt_d  = dcnt_q;
    ok_d    = ok_q;
    cen_d   = 1'b0;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:
        if (load_req) begin
          state_d = LOAD;
          addr_d  = '0;
          wri_d   = '0;
          ok_d    = 1'b0;
        end else if (start && ok_q) begin
          state_d = RUN;
          acc_d   = phase0;
          freq_d  = fcw;
          cen_d   = 1'b1;
        end
      LOAD:
        if (hs) begin
          d_d    = ld_data;
          wri_d  = addr_q;
          addr_d = addr_q + 6'd1;
          cen_d  = 1'b1;
          wen_d  = 1'b1;
          if (addr_q == 6'd63) begin
            state_d = IDLE;
            ok_d    = 1'b1;
          end
        end
      RUN: begin
        acc_d = acc_q + freq_q;
        if (stop) begin
          state_d = DRAIN;
          dcnt_d  = CW'(PIPE_LAT - 1);
        end else begin
          cen_d  = 1'b1;
          freq_d = fcw_load ? fcw : freq_q;
        end
      end
      default: begin
        // done is registered, so it is raised one count early to land in the final drain cycle
        done_d  = dcnt_q == CW'(1);
        state_d = (dcnt_q == '0) ? IDLE : state_q;
        dcnt_d  = (dcnt_q == '0) ? dcnt_q : dcnt_q - 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      freq_q  <= '0;
      addr_q  <= '0;
      wri_q   <= '0;
      d_q     <= '0;
      dcnt_q  <= '0;
      vsr_q   <= '0;
      cen_q   <= 1'b0;
      wen_q   <= 1'b0;
      ok_q    <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      freq_q  <= freq_d;
      addr_q  <= addr_d;
      wri_q   <= wri_d;
      d_q     <= d_d;
      dcnt_q  <= dcnt_d;
      vsr_q   <= {vsr_q[PIPE_LAT-2:0], cen_q & ~wen_q};
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      ok_q    <= ok_d;
      rdy_q   <= state_d == LOAD;
      done_q  <= done_d;
      busy_q  <= state_d != IDLE;
    end
  end
  assign ld_ready     = rdy_q;
  assign cen          = cen_q;
  assign wen_trans    = wen_q;
  assign index_wri    = wri_q;
  assign D            = d_q;
  assign index_qua    = acc_q[ACC_W-1 -: 3];
  assign index_rea    = acc_q[ACC_W-4 -: 6];
  assign index_cor    = acc_q[ACC_W-10 -: 7];
  assign table_ok     = ok_q;
  assign busy         = busy_q;
  assign sample_valid = vsr_q[PIPE_LAT-1];
  assign done         = done_q;
endmodule

// File: tb/tb_pac_seq.sv
// tb_pac_seq: directed checks of load, stream, wrap, drain and reset behaviour of pac_seq.
module tb_pac_seq;
  logic clk = 0, reset = 0, load_req = 0, ld_valid = 0, start = 0, stop = 0, fcw_load = 0;
  logic [47:0] ld_data = '0;
  logic [23:0] phase0 = '0, fcw = '0;
  logic ld_ready, cen, wen_trans, table_ok, busy, sample_valid, done;
  logic [5:0] index_wri, index_rea;
  logic [47:0] D;
  logic [2:0] index_qua;
  logic [6:0] index_cor;
  int checks = 0, errors = 0;

  pac_seq #(.ACC_W(24), .PIPE_LAT(10)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .start(start), .stop(stop), .phase0(phase0), .fcw(fcw),
    .fcw_load(fcw_load), .cen(cen), .wen_trans(wen_trans), .index_wri(index_wri), .D(D),
    .index_qua(index_qua), .index_rea(index_rea), .index_cor(index_cor), .table_ok(table_ok),
    .busy(busy), .sample_valid(sample_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_all();
    load_req = 1;
    tick();
    load_req = 0;
    ld_valid = 1;
    for (int j = 0; j < 64; j++) begin
      ld_data = 48'(j) * 48'h10001;
      tick();
    end
    ld_valid = 0;
  endtask

  initial begin
    int i, wr, dk, svc;
    logic hs;
    repeat (3) tick();
    chk("rst_ctrl", {cen, wen_trans, ld_ready, table_ok, busy, sample_valid, done}, 0);
    chk("rst_idx", {index_qua, index_rea, index_cor, index_wri}, 0);
    chk("rst_D", D, 0);
    reset = 1;
    start = 1;
    tick();
    start = 0;
    chk("start_no_table_busy", busy, 0);
    chk("start_no_table_cen", cen, 0);
    // gapped table load
    load_req = 1;
    tick();
    load_req = 0;
    chk("load_ready", ld_ready, 1);
    chk("load_busy", busy, 1);
    i = 0;
    wr = 0;
    for (int cyc = 0; wr < 64 && cyc < 200; cyc++) begin
      ld_valid = (cyc % 5 != 4) && (i < 64);
      ld_data = 48'(i) * 48'h10001;
      hs = ld_valid && ld_ready;
      if (hs) i++;
      tick();
      if (cen) begin
        chk("wr_wen", wen_trans, 1);
        chk("wr_addr", index_wri, wr);
        chk("wr_data", D, 48'(wr) * 48'h10001);
        wr++;
      end
    end
    ld_valid = 0;
    chk("write_count", wr, 64);
    chk("table_ok", table_ok, 1);
    tick();
    chk("load_idle_busy", busy, 0);
    chk("load_idle_ready", ld_ready, 0);
    // stream with wrap and frequency change
    phase0 = 24'hFFF000;
    fcw = 24'h001000;
    start = 1;
    tick();
    start = 0;
    chk("run_busy", busy, 1);
    chk("run_rd", {cen, wen_trans}, 2'b10);
    chk("ph0", {index_qua, index_rea, index_cor}, 16'hFFF0);
    tick();
    chk("ph1_wrap", {index_qua, index_rea, index_cor}, 16'h0000);
    chk("ph1_cen", cen, 1);
    tick();
    chk("ph2", {index_qua, index_rea, index_cor}, 16'h0010);
    fcw = 24'h000100;
    fcw_load = 1;
    tick();
    fcw_load = 0;
    chk("ph3_oldstep", {index_qua, index_rea, index_cor}, 16'h0020);
    tick();
    chk("ph4_newstep", {index_qua, index_rea, index_cor}, 16'h0021);
    tick();
    chk("ph5", {index_qua, index_rea, index_cor}, 16'h0022);
    stop = 1;
    fcw_load = 1;
    fcw = 24'h00ABCD;
    tick();
    stop = 0;
    fcw_load = 0;
    chk("stopfcw_cen", cen, 0);
    chk("stopfcw_busy", busy, 1);
    dk = 0;
    for (int k = 1; k <= 12; k++) begin
      if (done && dk == 0) dk = k;
      tick();
    end
    chk("drain_done_cycle", dk, 10);
    chk("drain_idle", busy, 0);
    // 20 reads, stop, drain; load_req during RUN must be ignored
    phase0 = 24'h123456;
    fcw = 24'h000001;
    start = 1;
    tick();
    start = 0;
    svc = 0;
    for (int n = 1; n <= 32; n++) begin
      chk("sd_cen", cen, n <= 20);
      chk("sd_valid", sample_valid, n >= 11 && n <= 30);
      chk("sd_done", done, n == 30);
      chk("sd_busy", busy, n <= 30);
      if (n == 6) chk("run_loadreq_ignored", ld_ready, 0);
      if (sample_valid) svc++;
      stop = (n == 20);
      load_req = (n == 5);
      tick();
    end
    chk("sd_valid_count", svc, 20);
    // load_req wins over start
    load_req = 1;
    start = 1;
    tick();
    load_req = 0;
    start = 0;
    chk("both_ready", ld_ready, 1);
    chk("both_cen", cen, 0);
    chk("both_ok_cleared", table_ok, 0);
    ld_valid = 1;
    for (int j = 0; j <= 30; j++) begin
      ld_data = 48'(j) * 48'h10001;
      tick();
    end
    ld_valid = 0;
    chk("mid_addr30", index_wri, 30);
    chk("mid_data30", D, 48'd30 * 48'h10001);
    reset = 0;
    tick();
    reset = 1;
    chk("midload_rst_ctrl", {busy, table_ok, ld_ready, cen, wen_trans}, 0);
    chk("midload_rst_wri", index_wri, 0);
    start = 1;
    tick();
    start = 0;
    chk("after_rst_start_ignored", busy, 0);
    // reset mid-RUN
    load_all();
    chk("reload_ok", table_ok, 1);
    start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    chk("prerst_cen", cen, 1);
    reset = 0;
    tick();
    reset = 1;
    chk("midrun_rst_valid", sample_valid, 0);
    chk("midrun_rst_ctrl", {cen, busy, table_ok}, 0);
    svc = 0;
    for (int k = 0; k < 15; k++) begin
      if (sample_valid) svc++;
      tick();
    end
    chk("no_late_valid", svc, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pac_seq.md
# pac_seq

Sequencer for the pipelined CORDIC sine-amplitude core. It loads the 64×48 coarse table through the core's write port, then streams read addresses from a phase accumulator: quadrant, ROM index and CORDIC residual. It drains the pipeline on stop and flags which output cycles carry valid `sin_amp` samples. The block sits directly in front of the core and owns all of its address and control inputs.

## Interface
- `ACC_W`, 24, phase accumulator width; the top 16 bits form the issued phase (≥16).
- `PIPE_LAT`, 10, core read latency in cycles, from a `cen` read cycle to the matching `sin_amp` (≥2).

- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-low.
- `load_req` in 1 — pulse: (re)load the table.
- `ld_valid` in 1 — table word valid.
- `ld_data` in 48 — table word.
- `ld_ready` out 1 — table word accepted when `ld_valid & ld_ready`.
- `start` in 1 — pulse: begin streaming.
- `stop` in 1 — pulse: end streaming and drain.
- `phase0` in ACC_W — initial phase, sampled on accepted `start`.
- `fcw` in ACC_W — frequency control word.
- `fcw_load` in 1 — update the frequency word while in RUN.
- `cen` out 1 — 1 = core table access this cycle.
- `wen_trans` out 1 — 1 = table write cycle; 0 = read cycle.
- `index_wri` out 6 — table write address.
- `D` out 48 — table write data.
- `index_qua` out 3 — quadrant = acc[ACC_W-1 -: 3].
- `index_rea` out 6 — table read address = acc[ACC_W-4 -: 6].
- `index_cor` out 7 — CORDIC residual = acc[ACC_W-10 -: 7].
- `table_ok` out 1 — all 64 entries written since reset.
- `busy` out 1 — state ≠ IDLE.
- `sample_valid` out 1 — core output is a valid sample this cycle.
- `done` out 1 — one-cycle pulse when DRAIN completes.

## Operation
- States: IDLE, LOAD, RUN, DRAIN. All outputs are registered.
- **IDLE**
  - `load_req` → LOAD: clears `index_wri` and `table_ok`.
  - `start & table_ok` → RUN: loads acc ← `phase0` and the frequency register ← `fcw`.
  - `start` without `table_ok` is ignored.
  - When `load_req` and `start` arrive together, `load_req` wins.
- **LOAD**
  - `ld_ready` = 1.
  - Each handshake registers `D` ← `ld_data` and the current address, and gives one cycle of `cen` = 1, `wen_trans` = 1.
  - `index_wri` increments after each write.
  - Write of entry 63 → IDLE, with `table_ok` = 1 from the next cycle.
  - Gaps in `ld_valid` produce `cen` = 0 cycles.
  - `start`, `stop` and `load_req` are ignored.
- **RUN**
  - Every cycle: `cen` = 1, `wen_trans` = 0, index outputs taken from the current acc.
  - acc ← acc + freq, modulo 2^ACC_W; wrap-around is silent.
  - `fcw_load` updates the frequency register; it takes effect on the next increment.
  - `stop` → DRAIN. When `stop` and `fcw_load` arrive together, `stop` wins.
  - `load_req` and `start` are ignored.
- **DRAIN**
  - `cen` = 0.
  - A down-counter starts at PIPE_LAT-1 on entry.
  - At 0 → IDLE and `done` = 1 for that cycle.
  - All requests are ignored.
- **Valid tracking:** a PIPE_LAT-bit shift register takes in (`cen & ~wen_trans`) each cycle; `sample_valid` = its last stage. The number of `sample_valid` cycles equals the number of read cycles issued.
- **Reset values** (reset low at any edge, including mid-LOAD or mid-RUN):
  - State → IDLE.
  - `cen`, `wen_trans`, `ld_ready`, `table_ok`, `busy`, `sample_valid`, `done` = 0.
  - Indices, `D`, acc and shift register = 0.
  - The table must be reloaded after any reset.

## Timing
- Request sampled at edge t → new state and its outputs valid in cycle t+1.
- The first RUN read cycle presents `phase0`'s bits; the second presents `phase0` + `fcw`.
- Load handshake at edge t → write cycle (`cen`, `wen_trans`, `index_wri`, `D`) in cycle t+1.
- Throughput: one table write per cycle when `ld_valid` is held high, so the minimum LOAD time is 64 cycles.
- The read cycle at cycle c yields `sample_valid` in cycle c+PIPE_LAT.
- `stop` sampled at edge t:
  - The last read is issued in cycle t.
  - DRAIN occupies cycles t+1 … t+PIPE_LAT.
  - `done` is asserted in cycle t+PIPE_LAT.
  - The last `sample_valid` is also in cycle t+PIPE_LAT.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles → every output is 0. Then `start` with `table_ok`=0 → `busy` stays 0.
- **Table load:** `load_req`, then 64 words `ld_data`=i·0x10001 with `ld_valid` low on every 5th cycle → exactly 64 write cycles with `index_wri` 0..63 matching `D`. `table_ok`=1 afterwards; the next `start` enters RUN.
- **Stream and wrap:**
  - `phase0`=0xFFF000, `fcw`=0x001000 → issued `{qua,rea,cor}` = 0xFFF0, 0x0000, 0x0010, …; acc wraps with no glitch.
  - `fcw_load` with 0x000100 → the step changes on the following cycle.
- **Stop and drain:** 20 reads, then `stop` → `cen` low for PIPE_LAT=10 cycles. Exactly 20 `sample_valid` cycles, the first 10 cycles after the first read. `done` pulses once in the 10th DRAIN cycle, then `busy`=0.
- **Simultaneous and ignored requests:**
  - `load_req`+`start` in the same IDLE cycle → LOAD.
  - `stop`+`fcw_load` in RUN → DRAIN.
  - `load_req` during RUN has no effect.
- **Reset mid-operation:** reset mid-LOAD at entry 30 → IDLE, `table_ok`=0, `index_wri`=0. Reset mid-RUN → `sample_valid` is 0 immediately, with no late valids.
